clock_time_setter: RTL and testbench

//  Button-driven time/date editor: the writer side of the clock counter chain (display is the reader).

---
 rtl/clock_time_setter_pkg.sv | 17 +
 rtl/clock_time_setter_month_days.sv | 13 +
 rtl/clock_time_setter.sv | 118 +++++++++++
 tb/tb_clock_time_setter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/clock_time_setter_pkg.sv
// clock_time_setter_pkg: field codes, FSM states and calendar/step helpers shared by the time setter
package clock_time_setter_pkg;
    localparam logic [2:0] FLD_YEAR  = 3'd0;
    localparam logic [2:0] FLD_MONTH = 3'd1;
    localparam logic [2:0] FLD_DAY   = 3'd2;
    localparam logic [2:0] FLD_HOUR  = 3'd3;
    localparam logic [2:0] FLD_MIN   = 3'd4;
    localparam logic [2:0] FLD_SEC   = 3'd5;
    typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT} state_t;
    function automatic logic is_leap(input logic [13:0] y);
        return (y[1:0] == 2'd0 && y % 14'd100 != 14'd0) || y % 14'd400 == 14'd0;
    endfunction
    // Single up/down step with wrap between lo and hi; no step when neither is set.
    function automatic logic [13:0] step(input logic [13:0] v, lo, hi, input logic up, dn);
        return up ? (v >= hi ? lo : v + 14'd1) : dn ? (v <= lo ? hi : v - 14'd1) : v;
    endfunction
endpackage

// File: rtl/clock_time_setter_month_days.sv
// month_days: days in a given month of a given year, leap-year aware
module month_days
    import clock_time_setter_pkg::*;
(
    input  logic [3:0]  month,
    input  logic [13:0] year,
    output logic [4:0]  dim
);
    always_comb begin
        dim = month == 4'd2 ? (is_leap(year) ? 5'd29 : 5'd28) :
              (month == 4'd4 || month == 4'd6 || month == 4'd9 || month == 4'd11) ? 5'd30 : 5'd31;
    end
endmodule

// File: rtl/clock_time_setter.sv
// clock_time_setter: button-driven time/date editor that snapshots, edits and reloads the clock chain
module clock_time_setter
    import clock_time_setter_pkg::*;
#(
    parameter int YEAR_MIN       = 2000,
    parameter int YEAR_MAX       = 2099,
    parameter int TIMEOUT_CYCLES = 500000000
)(
    input  logic        built_in_clk,
    input  logic        glob_rst,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        btn_ok,
    input  logic [5:0]  cur_sec,
    input  logic [5:0]  cur_min,
    input  logic [4:0]  cur_hour,
    input  logic [4:0]  cur_day,
    input  logic [3:0]  cur_month,
    input  logic [13:0] cur_year,
    output logic        set_active,
    output logic [2:0]  set_field,
    output logic [5:0]  set_sec,
    output logic [5:0]  set_min,
    output logic [4:0]  set_hour,
    output logic [4:0]  set_day,
    output logic [3:0]  set_month,
    output logic [13:0] set_year,
    output logic        load_time
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [13:0] YMIN = 14'(YEAR_MIN);
    localparam logic [13:0] YMAX = 14'(YEAR_MAX);
    state_t state;
    logic [3:0] btn_q, btn_p, ev;
    logic ev_mode, ev_inc, ev_dec, ev_ok, cap, adj, up, dn, load_r;
    logic [5:0] fu, fd, n_sec, n_min;
    logic [4:0] n_hour, n_day, dim;
    logic [3:0] n_month;
    logic [13:0] n_year;
    logic [TW-1:0] tcnt;
    assign ev = btn_q & ~btn_p;
    assign {ev_mode, ev_inc, ev_dec, ev_ok} = ev;
    // A reset landing inside the commit cycle must still suppress the strobe.
    assign load_time = load_r & ~glob_rst;
    always_comb begin
        cap = state == S_IDLE && ev_mode;
        adj = state == S_EDIT && !ev_ok && !ev_mode;
        up = adj && ev_inc && !ev_dec;
        dn = adj && ev_dec && !ev_inc;
        fu = {6{up}} & (6'd1 << set_field);
        fd = {6{dn}} & (6'd1 << set_field);
        n_year = cap ? (cur_year >= YMIN && cur_year <= YMAX ? cur_year : YMIN) :
                 step(set_year, YMIN, YMAX, fu[FLD_YEAR], fd[FLD_YEAR]);
        n_month = cap ? (cur_month >= 4'd1 && cur_month <= 4'd12 ? cur_month : 4'd1) :
                  4'(step(14'(set_month), 14'd1, 14'd12, fu[FLD_MONTH], fd[FLD_MONTH]));
    end
    month_days u_md (.month(n_month), .year(n_year), .dim(dim));
    // dim reflects the post-change month/year, so the day clamp happens in the same cycle.
    always_comb begin
        n_day = cap ? (cur_day >= 5'd1 && cur_day <= dim ? cur_day : 5'd1) :
                set_field == FLD_DAY ? 5'(step(14'(set_day), 14'd1, 14'(dim), fu[FLD_DAY], fd[FLD_DAY])) :
                (set_day > dim ? dim : set_day);
        n_hour = cap ? (cur_hour < 5'd24 ? cur_hour : 5'd0) :
                 5'(step(14'(set_hour), 14'd0, 14'd23, fu[FLD_HOUR], fd[FLD_HOUR]));
        n_min = cap ? (cur_min < 6'd60 ? cur_min : 6'd0) :
                6'(step(14'(set_min), 14'd0, 14'd59, fu[FLD_MIN], fd[FLD_MIN]));
        n_sec = cap ? (cur_sec < 6'd60 ? cur_sec : 6'd0) :
                6'(step(14'(set_sec), 14'd0, 14'd59, fu[FLD_SEC], fd[FLD_SEC]));
    end
    always_ff @(posedge built_in_clk) begin
        if (glob_rst) begin
            state <= S_IDLE;
            set_active <= 1'b0;
            set_field <= FLD_YEAR;
            load_r <= 1'b0;
            tcnt <= '0;
            btn_q <= '0;
            btn_p <= '0;
            set_sec <= 6'd0;
            set_min <= 6'd0;
            set_hour <= 5'd0;
            set_day <= 5'd1;
            set_month <= 4'd1;
            set_year <= YMIN;
        end else begin
            btn_q <= {btn_mode, btn_inc, btn_dec, btn_ok};
            btn_p <= btn_q;
            load_r <= 1'b0;
            {set_year, set_month, set_day, set_hour, set_min, set_sec} <=
                {n_year, n_month, n_day, n_hour, n_min, n_sec};
            case (state)
                S_IDLE: if (ev_mode) begin
                    state <= S_EDIT;
                    set_active <= 1'b1;
                    set_field <= FLD_YEAR;
                    tcnt <= '0;
                end
                S_EDIT: begin
                    tcnt <= |ev ? '0 : tcnt + 1'b1;
                    if (ev_ok) begin
                        state <= S_COMMIT;
                        load_r <= 1'b1;
                    end else if (ev_mode)
                        set_field <= set_field == FLD_SEC ? FLD_YEAR : set_field + 3'd1;
                    else if (!(|ev) && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state <= S_IDLE;
                        set_active <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    set_active <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_clock_time_setter.sv
// tb_clock_time_setter: vector table plus hand sequences for hold, timeout and reset-in-commit
module tb_clock_time_setter;
    typedef struct {
        logic [3:0]  b;
        logic [13:0] cy;
        logic [3:0]  cmo;
        logic [4:0]  cd, ch;
        logic [5:0]  cmi, cs;
        logic [43:0] e;
    } vec_t;
    localparam logic [3:0] M = 4'b1000, I = 4'b0100, D = 4'b0010, O = 4'b0001;
    logic built_in_clk = 1'b0, glob_rst = 1'b1;
    logic btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_ok = 1'b0;
    logic [5:0] cur_sec = '0, cur_min = '0;
    logic [4:0] cur_hour = '0, cur_day = 5'd1;
    logic [3:0] cur_month = 4'd1;
    logic [13:0] cur_year = 14'd2000;
    logic set_active, load_time;
    logic [2:0] set_field;
    logic [5:0] set_sec, set_min;
    logic [4:0] set_hour, set_day;
    logic [3:0] set_month;
    logic [13:0] set_year;
    int total = 0, bad = 0, loads = 0;
    logic [43:0] exp_q[$];
    vec_t vt[$];
    clock_time_setter #(.YEAR_MIN(2000), .YEAR_MAX(2099), .TIMEOUT_CYCLES(100)) dut (
        .built_in_clk(built_in_clk), .glob_rst(glob_rst),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_ok(btn_ok),
        .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
        .cur_day(cur_day), .cur_month(cur_month), .cur_year(cur_year),
        .set_active(set_active), .set_field(set_field),
        .set_sec(set_sec), .set_min(set_min), .set_hour(set_hour),
        .set_day(set_day), .set_month(set_month), .set_year(set_year),
        .load_time(load_time)
    );
    always #5 built_in_clk = ~built_in_clk;
    always @(negedge built_in_clk) if (load_time) loads++;
    function automatic logic [43:0] pk(input logic a, input logic [2:0] f, input int y, mo, d, h, mi, s);
        return {a, f, 14'(y), 4'(mo), 5'(d), 5'(h), 6'(mi), 6'(s)};
    endfunction
    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask
    task automatic check_out(input string nm);
        logic [43:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got empty scoreboard want entry", nm);
        end else begin
            e = exp_q.pop_front();
            chk(nm, 64'(pk(set_active, set_field, set_year, set_month, set_day, set_hour, set_min, set_sec)), 64'(e));
        end
    endtask
    task automatic press(input logic [3:0] b);
        @(negedge built_in_clk);
        {btn_mode, btn_inc, btn_dec, btn_ok} = b;
        @(negedge built_in_clk);
        {btn_mode, btn_inc, btn_dec, btn_ok} = 4'b0;
        repeat (3) @(negedge built_in_clk);
    endtask
    task automatic run_vec(input vec_t v, input string nm);
        {cur_year, cur_month, cur_day, cur_hour, cur_min, cur_sec} = {v.cy, v.cmo, v.cd, v.ch, v.cmi, v.cs};
        exp_q.push_back(v.e);
        press(v.b);
        check_out(nm);
    endtask
    task automatic add(input logic [3:0] b, input int cy, cmo, cd, ch, cmi, cs, input logic [43:0] e);
        vt.push_back('{b, 14'(cy), 4'(cmo), 5'(cd), 5'(ch), 6'(cmi), 6'(cs), e});
    endtask
    initial begin
        add(M, 2024, 3, 15, 10, 20, 30, pk(1, 0, 2024, 3, 15, 10, 20, 30));
        add(O, 2024, 3, 15, 10, 20, 30, pk(0, 0, 2024, 3, 15, 10, 20, 30));
        add(M, 2024, 3, 31, 0, 20, 59, pk(1, 0, 2024, 3, 31, 0, 20, 59));
        add(M, 2024, 3, 31, 0, 20, 59, pk(1, 1, 2024, 3, 31, 0, 20, 59));
        add(D, 2024, 3, 31, 0, 20, 59, pk(1, 1, 2024, 2, 29, 0, 20, 59));
        add(M | I, 2024, 3, 31, 0, 20, 59, pk(1, 2, 2024, 2, 29, 0, 20, 59));
        add(M, 2024, 3, 31, 0, 20, 59, pk(1, 3, 2024, 2, 29, 0, 20, 59));
        add(D, 2024, 3, 31, 0, 20, 59, pk(1, 3, 2024, 2, 29, 23, 20, 59));
        add(M, 2024, 3, 31, 0, 20, 59, pk(1, 4, 2024, 2, 29, 23, 20, 59));
        add(M, 2024, 3, 31, 0, 20, 59, pk(1, 5, 2024, 2, 29, 23, 20, 59));
        add(I, 2024, 3, 31, 0, 20, 59, pk(1, 5, 2024, 2, 29, 23, 20, 0));
        add(D, 2024, 3, 31, 0, 20, 59, pk(1, 5, 2024, 2, 29, 23, 20, 59));
        add(I | D, 2024, 3, 31, 0, 20, 59, pk(1, 5, 2024, 2, 29, 23, 20, 59));
        add(M, 2024, 3, 31, 0, 20, 59, pk(1, 0, 2024, 2, 29, 23, 20, 59));
        add(I, 2024, 3, 31, 0, 20, 59, pk(1, 0, 2025, 2, 28, 23, 20, 59));
        add(D, 2024, 3, 31, 0, 20, 59, pk(1, 0, 2024, 2, 28, 23, 20, 59));
        add(M | O, 2024, 3, 31, 0, 20, 59, pk(0, 0, 2024, 2, 28, 23, 20, 59));
        add(M, 2099, 12, 31, 23, 59, 59, pk(1, 0, 2099, 12, 31, 23, 59, 59));
        add(I, 2099, 12, 31, 23, 59, 59, pk(1, 0, 2000, 12, 31, 23, 59, 59));
        add(D, 2099, 12, 31, 23, 59, 59, pk(1, 0, 2099, 12, 31, 23, 59, 59));
        add(M, 2099, 12, 31, 23, 59, 59, pk(1, 1, 2099, 12, 31, 23, 59, 59));
        add(I, 2099, 12, 31, 23, 59, 59, pk(1, 1, 2099, 1, 31, 23, 59, 59));
        add(M, 2099, 12, 31, 23, 59, 59, pk(1, 2, 2099, 1, 31, 23, 59, 59));
        add(M, 2100, 0, 30, 24, 60, 63, pk(1, 0, 2000, 1, 30, 0, 0, 0));
        add(O, 2100, 0, 30, 24, 60, 63, pk(0, 0, 2000, 1, 30, 0, 0, 0));
        add(M, 2023, 2, 30, 5, 6, 7, pk(1, 0, 2023, 2, 1, 5, 6, 7));
        add(I, 2023, 2, 30, 5, 6, 7, pk(1, 0, 2024, 2, 1, 5, 6, 7));
        add(O, 2023, 2, 30, 5, 6, 7, pk(0, 0, 2024, 2, 1, 5, 6, 7));
        add(I, 2023, 2, 30, 5, 6, 7, pk(0, 0, 2024, 2, 1, 5, 6, 7));
        repeat (2) @(negedge built_in_clk);
        glob_rst = 1'b0;
        exp_q.push_back(pk(0, 0, 2000, 1, 1, 0, 0, 0));
        check_out("reset");
        chk("reset_load", 64'(load_time), 64'd0);
        for (int i = 0; i < 23; i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
            if (i == 1) chk("commit1_loads", 64'(loads), 64'd1);
            if (i == 16) chk("commit2_loads", 64'(loads), 64'd2);
        end
        @(negedge built_in_clk);
        btn_inc = 1'b1;
        repeat (60) @(negedge built_in_clk);
        btn_inc = 1'b0;
        repeat (3) @(negedge built_in_clk);
        exp_q.push_back(pk(1, 2, 2099, 1, 1, 23, 59, 59));
        check_out("hold_inc");
        repeat (150) @(negedge built_in_clk);
        chk("timeout_active", 64'(set_active), 64'd0);
        chk("timeout_loads", 64'(loads), 64'd2);
        for (int i = 23; i < vt.size(); i++)
            run_vec(vt[i], $sformatf("vec%0d", i));
        chk("commit4_loads", 64'(loads), 64'd4);
        press(M);
        chk("pre_rst_active", 64'(set_active), 64'd1);
        @(negedge built_in_clk);
        btn_ok = 1'b1;
        @(posedge built_in_clk);
        @(posedge built_in_clk);
        #1;
        glob_rst = 1'b1;
        btn_ok = 1'b0;
        repeat (2) @(negedge built_in_clk);
        glob_rst = 1'b0;
        repeat (2) @(negedge built_in_clk);
        exp_q.push_back(pk(0, 0, 2000, 1, 1, 0, 0, 0));
        check_out("rst_in_commit");
        chk("rst_in_commit_loads", 64'(loads), 64'd4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
